// File: rtl/isa_fetch_decode.sv
// Instruction fetch/decode stage: pops 64-bit instructions from the ISA FIFO and dispatches engine commands.
// Define ISA_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT; otherwise they retire as NOP.
module isa_fetch_decode #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [3:0]        cmd_op,
    output logic [31:0]       cmd_addr,
    output logic [15:0]       cmd_len,
    output logic [11:0]       cmd_arg,
    input  logic              engine_busy,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_SYNC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_CONV  = 4'h2;
    localparam logic [3:0] OP_POOL  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_SYNC  = 4'h5;
    localparam logic [3:0] OP_END   = 4'hF;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              retire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            done_q  <= done_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        done_d     = done_q;
        error_d    = error_q;
        cnt_d      = cnt_q;
        fifo_rd_en = 1'b0;
        cmd_valid  = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_REQ;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_REQ: begin
                if (!fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                instr_d = fifo_dout;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (instr_q[63:60])
                    OP_LOAD, OP_CONV, OP_POOL, OP_STORE: begin
                        cmd_valid = 1'b1;
                        if (cmd_ready) begin
                            retire  = 1'b1;
                            state_d = S_REQ;
                        end
                    end
                    OP_NOP: begin
                        retire  = 1'b1;
                        state_d = S_REQ;
                    end
                    OP_SYNC: state_d = S_SYNC;
                    OP_END: begin
                        retire  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                    default: begin
`ifdef ISA_ILLEGAL_TRAP_EN
                        error_d = 1'b1;
                        state_d = S_HALT;
`else
                        retire  = 1'b1;
                        state_d = S_REQ;
`endif
                    end
                endcase
            end
            S_SYNC: begin
                if (!engine_busy) begin
                    retire  = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Saturate so software never sees the count wrap to a small value.
        if (retire && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign cmd_op      = instr_q[63:60];
    assign cmd_addr    = instr_q[59:28];
    assign cmd_len     = instr_q[27:12];
    assign cmd_arg     = instr_q[11:0];
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign error       = error_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_isa_fetch_decode.sv
// Randomized bench for isa_fetch_decode: FIFO and engines modelled in the bench, programs
// checked against a per-instruction reference of expected commands, retire count and flags.
module tb_isa_fetch_decode;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset, start, fifo_empty, cmd_ready, engine_busy;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en, cmd_valid, busy, done, error;
    logic [3:0]        cmd_op;
    logic [31:0]       cmd_addr;
    logic [15:0]       cmd_len;
    logic [11:0]       cmd_arg;
    logic [CNT_W-1:0]  instr_count;

    // narrow-counter copy shares all inputs; only its count is observed
    logic        s_rd_en, s_valid, s_busy, s_done, s_error;
    logic [3:0]  s_op;
    logic [31:0] s_addr;
    logic [15:0] s_len;
    logic [11:0] s_arg;
    logic [1:0]  s_count;

    logic [63:0] cmd_fields;
    assign cmd_fields = {cmd_op, cmd_addr, cmd_len, cmd_arg};

    always #5 clk = ~clk;

    isa_fetch_decode #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_arg(cmd_arg), .engine_busy(engine_busy), .busy(busy), .done(done),
        .error(error), .instr_count(instr_count)
    );

    isa_fetch_decode #(.DATA_W(DATA_W), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(s_rd_en), .cmd_valid(s_valid),
        .cmd_ready(cmd_ready), .cmd_op(s_op), .cmd_addr(s_addr), .cmd_len(s_len),
        .cmd_arg(s_arg), .engine_busy(engine_busy), .busy(s_busy), .done(s_done),
        .error(s_error), .instr_count(s_count)
    );

    int          errors = 0;
    int          checks = 0;
    logic [63:0] prog[$], q[$], pend[$], exp_cmd[$];
    int unsigned cyc, rd_cyc, ready_pct, busy_pct, exp_cnt;
    bit          push_en, exp_done, exp_err, prev_valid, prev_ready;
    logic [63:0] prev_fields;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mk(input logic [3:0] op, input logic [31:0] addr,
                                       input logic [15:0] len, input logic [11:0] arg);
        return {op, addr, len, arg};
    endfunction

    // One clock: monitor the current cycle, advance, then apply FIFO/engine responses.
    task automatic step();
        logic rd;
        rd = fifo_rd_en;
        if (rd) check_eq("no_pop_empty", fifo_empty, 1'b0);
        if (cmd_valid) begin
            if (prev_valid && !prev_ready) check_eq("cmd_stable", cmd_fields, prev_fields);
            else check_eq("cmd_latency", cyc, rd_cyc + 2);
            if (cmd_ready) begin
                if (exp_cmd.size() == 0) check_eq("cmd_unexpected", cmd_fields, 64'hX);
                else check_eq("cmd_fields", cmd_fields, exp_cmd.pop_front());
            end
        end
        prev_valid  = cmd_valid;
        prev_ready  = cmd_ready;
        prev_fields = cmd_fields;
        if (rd) rd_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        if (rd && q.size() > 0) fifo_dout = q.pop_front();
        if (push_en && pend.size() > 0 && $urandom_range(0, 1) == 1) q.push_back(pend.pop_front());
        fifo_empty  = (q.size() == 0);
        cmd_ready   = ($urandom_range(0, 99) < ready_pct);
        engine_busy = ($urandom_range(0, 99) < busy_pct);
        #1;
    endtask

    // Reference: walk the program in order, applying the opcode rules.
    task automatic model();
        bit stop;
        logic [3:0] op;
        stop = 0;
        exp_cmd.delete();
        exp_cnt  = 0;
        exp_done = 0;
        exp_err  = 0;
        foreach (prog[i]) begin
            if (!stop) begin
                op = prog[i][63:60];
                if (op >= 4'h1 && op <= 4'h4) begin
                    exp_cmd.push_back(prog[i]);
                    exp_cnt++;
                end else if (op == 4'h0 || op == 4'h5) begin
                    exp_cnt++;
                end else if (op == 4'hF) begin
                    exp_cnt++;
                    exp_done = 1;
                    stop = 1;
                end else begin
`ifdef ISA_ILLEGAL_TRAP_EN
                    exp_err = 1;
                    stop = 1;
`else
                    exp_cnt++;
`endif
                end
            end
        end
    endtask

    task automatic run_prog(input int unsigned hold);
        int unsigned n;
        model();
        q.delete();
        pend = prog;
        push_en = (hold == 0);
        start = 1'b1;
        step();
        for (int unsigned i = 0; i < hold; i++) begin
            check_eq("empty_no_pop", fifo_rd_en, 1'b0);
            check_eq("empty_busy", busy, 1'b1);
            step();
        end
        push_en = 1;
        n = 0;
        while (!(error || (!busy && done)) && n < 3000) begin
            step();
            n++;
        end
        check_eq("prog_timeout", n < 3000, 1'b1);
        check_eq("done", done, exp_done);
        check_eq("error", error, exp_err);
        check_eq("busy_end", busy, exp_err);
        check_eq("instr_count", instr_count, exp_cnt);
        check_eq("sat_count", s_count, (exp_cnt > 3) ? 3 : exp_cnt);
        check_eq("cmds_left", exp_cmd.size(), 0);
    endtask

    function automatic logic [63:0] rand_instr();
        logic [3:0] op;
        int unsigned r;
        r = $urandom_range(0, 19);
        if (r < 15) op = 4'($urandom_range(1, 4));
        else if (r < 17) op = 4'h0;
        else if (r < 19) op = 4'h5;
        else op = 4'($urandom_range(6, 14));
        return mk(op, $urandom, 16'($urandom), 12'($urandom));
    endfunction

    initial begin
        int unsigned n;
        reset = 1'b1; start = 1'b0; fifo_empty = 1'b1; cmd_ready = 1'b0;
        engine_busy = 1'b0; fifo_dout = '0; cyc = 0; rd_cyc = 0;
        ready_pct = 0; busy_pct = 0; push_en = 0; prev_valid = 0; prev_ready = 0; prev_fields = '0;
        repeat (3) step();
        reset = 1'b0;
        check_eq("rst_rd_en", fifo_rd_en, 1'b0);
        check_eq("rst_valid", cmd_valid, 1'b0);
        check_eq("rst_fields", cmd_fields, 64'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        check_eq("rst_count", instr_count, 0);

        ready_pct = 100; busy_pct = 0;
        prog = '{mk(4'h1, 32'h0000_1000, 16'h0040, 12'h0), mk(4'hF, 32'h0, 16'h0, 12'h0)};
        run_prog(0);

        ready_pct = 60;
        prog = '{mk(4'h0, 32'h0, 16'h0, 12'h0), mk(4'hF, 32'h0, 16'h0, 12'h0)};
        run_prog(10);

        busy_pct = 85;
        prog = '{mk(4'h5, 32'h0, 16'h0, 12'h0), mk(4'h3, 32'hCAFE_0000, 16'h1234, 12'h5A5),
                 mk(4'hF, 32'h0, 16'h0, 12'h0)};
        run_prog(0);

        busy_pct = 30;
        prog = '{mk(4'h7, 32'h0, 16'h0, 12'h0), mk(4'h2, 32'h1, 16'h2, 12'h3),
                 mk(4'hF, 32'h0, 16'h0, 12'h0)};
        run_prog(0);

        for (int t = 0; t < 30; t++) begin
            ready_pct = $urandom_range(20, 100);
            busy_pct  = $urandom_range(0, 70);
            prog.delete();
            n = $urandom_range(1, 12);
            for (int unsigned k = 0; k < n; k++) prog.push_back(rand_instr());
            prog.push_back(mk(4'hF, $urandom, 16'($urandom), 12'($urandom)));
            run_prog($urandom_range(0, 3));
        end

        // A stalled CONV holds steady, then reset clears the outstanding command.
        ready_pct = 0;
        prog = '{mk(4'h2, 32'hDEAD_BEEF, 16'h0100, 12'h0AB)};
        model();
        q.delete();
        pend = prog;
        push_en = 1;
        start = 1'b1;
        step();
        n = 0;
        while (!cmd_valid && n < 100) begin
            step();
            n++;
        end
        check_eq("stall_valid_seen", cmd_valid, 1'b1);
        repeat (5) step();
        check_eq("stall_valid_held", cmd_valid, 1'b1);
        check_eq("stall_no_retire", instr_count, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("mid_rst_valid", cmd_valid, 1'b0);
        check_eq("mid_rst_count", instr_count, 0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_fields", cmd_fields, 64'h0);
        check_eq("mid_rst_rd_en", fifo_rd_en, 1'b0);
        exp_cmd.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
